// File: rtl/rr_grant_pkg.sv
// Shared types, defaults and helpers for the rr_grant_ctrl round-robin arbiter.
package rr_grant_pkg;

   localparam int unsigned DefaultWidth   = 8;
   localparam int unsigned DefaultMaxHold = 16;
   // Widest request vector onehot_to_index can encode.
   localparam int unsigned MaxWidth       = 64;

   typedef enum logic [0:0] {
      StIdle,
      StOwned
   } state_e;

   function automatic int unsigned onehot_to_index(input logic [MaxWidth-1:0] vec);
      int unsigned idx = 0;
      for (int unsigned i = 0; i < MaxWidth; i++) begin
         if (vec[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// Requester-side bundle of the round-robin arbiter: requests in, registered grant out.
interface rr_grant_ctrl_if #(
   parameter int unsigned WIDTH = rr_grant_pkg::DefaultWidth
) ();

   localparam int unsigned IdxW = $clog2(WIDTH);

   logic [WIDTH-1:0] req;
   logic [WIDTH-1:0] grant;
   logic [IdxW-1:0]  grant_id;
   logic             busy;
   logic             preempt;

   modport master (
      output req,
      input  grant,
      input  grant_id,
      input  busy,
      input  preempt
   );

   modport slave (
      input  req,
      output grant,
      output grant_id,
      output busy,
      output preempt
   );

endinterface

// File: rtl/rr_grant_ctrl_bitscan.sv
// Lowest-set-bit isolation: vec & ~(vec - 1), all-zero in gives all-zero out.
module rr_grant_ctrl_bitscan #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [WIDTH-1:0] lsb_o
);

   assign lsb_o = vec_i & ~(vec_i - WIDTH'(1));

endmodule

// File: rtl/rr_grant_ctrl.sv
// Registered round-robin arbiter with hold-until-release grants.
// Optional timeout handoff is built when RR_GRANT_CTRL_TIMEOUT_EN is defined.
module rr_grant_ctrl
   import rr_grant_pkg::*;
#(
   parameter int unsigned WIDTH    = DefaultWidth,
   parameter int unsigned MAX_HOLD = DefaultMaxHold
) (
   input logic           clk,
   input logic           rst_n,
   rr_grant_ctrl_if.slave bus
);

   localparam int unsigned IdxW = $clog2(WIDTH);

   if (WIDTH < 2 || WIDTH > MaxWidth || MAX_HOLD < 2) begin : g_bad_param
      $error("rr_grant_ctrl: WIDTH must be 2..64 and MAX_HOLD >= 2");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] grant_q, grant_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic [IdxW-1:0]  grant_id_q, grant_id_d;
   logic             busy_q, busy_d;
   logic             preempt_q, preempt_d;

   logic [WIDTH-1:0] req, mask, cand, cand_masked, scan_vec, win;
   logic             owner_req, others_req, timeout_hit;

   assign req        = bus.req;
   assign owner_req  = |(req & grant_q);
   assign others_req = |(req & ~grant_q);

   // Owner is excluded so a timeout handoff never re-picks it; its bit is
   // already low on release and grant_q is zero in IDLE.
   assign cand        = req & ~grant_q;
   assign mask        = ~((last_q << 1) - WIDTH'(1));
   assign cand_masked = cand & mask;
   assign scan_vec    = (|cand_masked) ? cand_masked : cand;

   rr_grant_ctrl_bitscan #(
      .WIDTH (WIDTH)
   ) u_bitscan (
      .vec_i (scan_vec),
      .lsb_o (win)
   );

`ifdef RR_GRANT_CTRL_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign timeout_hit = (cnt_q == CntW'(MAX_HOLD - 1));

   // Cleared on any grant change; saturates so a late arrival is handed over at once.
   always_comb begin
      cnt_d = cnt_q;
      if (grant_d != grant_q) begin
         cnt_d = '0;
      end else if (state_q == StOwned && !timeout_hit) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      preempt_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (|req) begin
               grant_d = win;
               last_d  = win;
               state_d = StOwned;
            end
         end
         StOwned: begin
            if (owner_req) begin
               if (timeout_hit && others_req) begin
                  grant_d   = win;
                  last_d    = win;
                  preempt_d = 1'b1;
               end
            end else if (others_req) begin
               grant_d = win;
               last_d  = win;
            end else begin
               grant_d = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      grant_id_d = IdxW'(onehot_to_index(MaxWidth'(grant_d)));
      busy_d     = |grant_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         grant_q    <= '0;
         last_q     <= WIDTH'(1) << (WIDTH - 1);
         grant_id_q <= '0;
         busy_q     <= 1'b0;
         preempt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         grant_id_q <= grant_id_d;
         busy_q     <= busy_d;
         preempt_q  <= preempt_d;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.grant_id = grant_id_q;
   assign bus.busy     = busy_q;
   assign bus.preempt  = preempt_q;

endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Registered round-robin arbiter that shares one resource among WIDTH requesters with hold-until-release grants. It sits between the requester ports and the shared datapath. Each cycle it isolates the lowest set bit of the rotated request vector, and the winner owns the resource until it drops its request. The grant is one-hot and registered, so it drives mux selects and enables directly.

## Interface
- WIDTH, 8: number of requesters; must be ≥2.
- MAX_HOLD, 16: maximum consecutive grant cycles before forced handoff. Used only with RR_GRANT_CTRL_TIMEOUT_EN; must be ≥2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  WIDTH  request per requester; held high for the whole tenure, dropped to release.
- grant  out  WIDTH  registered one-hot grant, or all-zero.
- grant_id  out  $clog2(WIDTH)  binary index of the grant bit; 0 when grant is zero.
- busy  out  1  equals |grant.
- preempt  out  1  one-cycle pulse coinciding with the first cycle of a grant that was forced by timeout.

## Operation
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - grant=0, grant_id=0, busy=0, preempt=0.
  - Hold counter is 0.
  - Priority pointer last = one-hot bit WIDTH-1, so requester 0 has highest priority after reset.
- Two states:
  - IDLE (grant==0).
  - OWNED (grant!=0).
- Arbitration function:
  - mask = bits strictly above last.
  - If (req & mask) != 0, win = lowest set bit of (req & mask); otherwise win = lowest set bit of req.
  - Lowest-set-bit isolation is x & ~(x-1), computed at WIDTH bits.
- IDLE:
  - If |req, then next grant=win, last=win, state→OWNED.
  - Otherwise stay IDLE.
- OWNED, owner's req bit high:
  - Grant is held regardless of other requests.
  - With timeout enabled, see Configuration.
- OWNED, owner's req bit low (release):
  - If other requests are pending, next grant=win computed on the current req, with no idle bubble.
  - Otherwise grant→0 and state→IDLE.
- The owner cannot win the re-arbitration on its own release cycle because its req bit is 0.
- Requests from non-owners that rise and fall while the resource is OWNED are not remembered. There is no request latching.
- grant_id and busy are registered together with grant and are always mutually consistent.

## Timing
- Latency: a req sampled high in IDLE produces grant on the next rising edge (1 cycle).
- Handoff: the release cycle is followed by the new owner's grant on the next edge. No dead cycle is inserted.
- The owner sees its grant drop exactly one cycle after it drops req. The owner must not rely on grant during that cycle.
- Reset mid-tenure: grant clears asynchronously, and the pointer returns to bit WIDTH-1.
- Simultaneous release and new request of the same bit: the bit is not granted that cycle (req is low). If other requesters are idle, that requester wins the following IDLE arbitration.
- Wrap-around: if last = bit WIDTH-1, mask is empty and the search starts at bit 0.

## Configuration
- RR_GRANT_CTRL_TIMEOUT_EN defined:
  - The hold counter (width $clog2(MAX_HOLD+1)) counts cycles in OWNED and clears on every new grant.
  - When counter==MAX_HOLD-1 and (req & ~grant)!=0, the next grant is win computed over (req & ~grant), and preempt=1 for that cycle.
  - With no other requester, the owner keeps the grant and the counter saturates.
- RR_GRANT_CTRL_TIMEOUT_EN not defined:
  - No counter is built; preempt is tied 0.
  - Tenure is unbounded.
  - The MAX_HOLD parameter is accepted but ignored.

## Structure
- Shared package rr_grant_pkg holds:
  - the state enum (IDLE, OWNED);
  - a function onehot_to_index(WIDTH);
  - the default constants for WIDTH and MAX_HOLD.
- Sub-module: the existing bitscan block, instantiated once on the selected vector (masked or unmasked req).
- The top level holds:
  - the mask generation, (last<<1) negated minus-one form;
  - the state, pointer and counter registers;
  - the output registers.

## Test plan
All scenarios use WIDTH=4.
- Reset, then req=4'b1010 → grant=0010, grant_id=1, busy=1 one edge later.
- Handoff: hold req=1010 three cycles, then set req=1000 → grant stays 0010 through the hold, then grant=1000 on the very next edge with no zero cycle.
- Fairness: req=1111, each owner drops its req for one cycle on its first granted cycle then reasserts → grant sequence 0001, 0010, 0100, 1000, 0001.
- Wrap: pointer at 1000 after a grant to 3, release, req=0101 → grant=0001.
- Timeout: macro defined, MAX_HOLD=4, req=0011 held constant → grant=0001 for 4 cycles, then grant=0010 with preempt=1 for one cycle. Without the macro, grant=0001 persists for 100 cycles and preempt stays 0.
- Reset mid-tenure: grant=0100, assert rst_n=0 → grant=0 immediately. Release reset with req=1100 → grant=0100, because the pointer restarted from requester 0.
